// File: rtl/dtw_command_arbiter_if.sv
// rtl/dtw_command_arbiter_if.sv - engine-bank, training and command signals of the DTW command arbiter
interface dtw_command_arbiter_if #(
  parameter int N_WORDS = 8,
  parameter int SCORE_W = 27,
  parameter int SEL_W   = 4
);
  logic                         training_enable;
  logic [SEL_W-1:0]             training_select;
  logic [N_WORDS*SCORE_W-1:0]   dtw_score;
  logic [N_WORDS-1:0]           dtw_done;
  logic [SCORE_W-1:0]           noise_score;
  logic                         noise_done;
  logic [N_WORDS-1:0]           train;
  logic                         noise_train;
  logic [SEL_W-1:0]             command;
  logic                         command_valid;
  logic                         busy;

  // Side that drives the engine results and training controls.
  modport master (
    output training_enable, training_select, dtw_score, dtw_done, noise_score, noise_done,
    input  train, noise_train, command, command_valid, busy
  );

  // The arbiter itself.
  modport slave (
    input  training_enable, training_select, dtw_score, dtw_done, noise_score, noise_done,
    output train, noise_train, command, command_valid, busy
  );
endinterface

// File: rtl/dtw_command_arbiter.sv
// rtl/dtw_command_arbiter.sv - best-template scan against noise with margin, command pulse and train strobes
module dtw_command_arbiter #(
  parameter int N_WORDS  = 8,
  parameter int SCORE_W  = 27,
  parameter int SEL_W    = 4,
  parameter int CMD_BASE = 4,
  parameter int MARGIN   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  dtw_command_arbiter_if.slave  bus
);
  localparam int                IDX_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_WORDS - 1);
  localparam logic [SEL_W-1:0]  CMD_BASE_V = SEL_W'(CMD_BASE);
  localparam logic [SCORE_W:0]  MARGIN_EXT = (SCORE_W + 1)'(MARGIN);

  // Command codes must fit in SEL_W bits and code 0 is reserved for "no command".
  if ((CMD_BASE + N_WORDS > (1 << SEL_W)) || (CMD_BASE == 0)) begin : g_bad_params
    $error("dtw_command_arbiter: CMD_BASE/N_WORDS do not fit in SEL_W or CMD_BASE is 0");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

  state_t               state, state_d;
  logic                 all_done, all_done_q, start, abort, accept;
  logic [SCORE_W-1:0]   snap [N_WORDS];
  logic [SCORE_W-1:0]   noise_snap, best_val, cur_score;
  logic [IDX_W-1:0]     best_idx, idx;
  logic [N_WORDS-1:0]   train_q, train_d;
  logic                 noise_train_q, noise_train_d;
  logic [SEL_W-1:0]     command_q;
  logic                 command_valid_q;

  // A decision starts only on the rising edge of the combined done, never in training mode.
  assign all_done  = (&bus.dtw_done) & bus.noise_done;
  assign start     = all_done & ~all_done_q & ~bus.training_enable & (state == IDLE);
  assign abort     = bus.training_enable & (state != IDLE);
  assign cur_score = snap[idx];
  // One extra bit so best+MARGIN cannot wrap around and falsely beat the noise score.
  assign accept    = (({1'b0, best_val} + MARGIN_EXT) < {1'b0, noise_snap});

  assign bus.train         = train_q;
  assign bus.noise_train   = noise_train_q;
  assign bus.command       = command_q;
  assign bus.command_valid = command_valid_q;
  assign bus.busy          = (state != IDLE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic; training mode pulls any scan back to idle.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (abort) state_d = IDLE;
               else if (idx == LAST_IDX) state_d = DECIDE;
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Training select decode: 0 is noise, CMD_BASE.. maps to templates, anything else selects nothing.
  always_comb begin
    train_d       = '0;
    noise_train_d = 1'b0;
    if (bus.training_enable) begin
      if (bus.training_select == '0) noise_train_d = 1'b1;
      for (int i = 0; i < N_WORDS; i++) begin
        if (bus.training_select == SEL_W'(CMD_BASE + i)) train_d[i] = 1'b1;
      end
    end
  end

  // Snapshot, sequential minimum scan, decision pulse and registered train strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      all_done_q      <= 1'b0;
      train_q         <= '0;
      noise_train_q   <= 1'b0;
      command_q       <= '0;
      command_valid_q <= 1'b0;
      noise_snap      <= '0;
      best_val        <= '0;
      best_idx        <= '0;
      idx             <= '0;
      for (int i = 0; i < N_WORDS; i++) snap[i] <= '0;
    end else begin
      all_done_q      <= all_done;
      train_q         <= train_d;
      noise_train_q   <= noise_train_d;
      command_q       <= '0;
      command_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_WORDS; i++) snap[i] <= bus.dtw_score[i*SCORE_W +: SCORE_W];
            noise_snap <= bus.noise_score;
            best_val   <= '1;
            best_idx   <= '0;
            idx        <= '0;
          end
        end
        SCAN: begin
          if (!abort) begin
            // Strict compare keeps the earliest index on ties.
            if (cur_score < best_val) begin
              best_val <= cur_score;
              best_idx <= idx;
            end
            idx <= idx + 1'b1;
          end
        end
        DECIDE: begin
          if (!abort) begin
            command_q       <= accept ? (CMD_BASE_V + SEL_W'(best_idx)) : '0;
            command_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dtw_command_arbiter.sv
// tb/tb_dtw_command_arbiter.sv - directed self-checking bench for dtw_command_arbiter
module tb_dtw_command_arbiter;
  localparam int N  = 8;
  localparam int SW = 27;
  localparam int SL = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dtw_command_arbiter_if #(.N_WORDS(N), .SCORE_W(SW), .SEL_W(SL)) b0 ();
  dtw_command_arbiter_if #(.N_WORDS(N), .SCORE_W(SW), .SEL_W(SL)) b1 ();

  dtw_command_arbiter #(.N_WORDS(N), .SCORE_W(SW), .SEL_W(SL), .CMD_BASE(4), .MARGIN(0))
    dut0 (.clock(clock), .reset(reset), .bus(b0.slave));
  dtw_command_arbiter #(.N_WORDS(N), .SCORE_W(SW), .SEL_W(SL), .CMD_BASE(4), .MARGIN(100))
    dut1 (.clock(clock), .reset(reset), .bus(b1.slave));

  int errors = 0;
  int checks = 0;

  logic [SW-1:0] sc [N];
  logic [SW-1:0] nz;

  int        p0_cnt, p0_cyc, p1_cnt, stray;
  logic [SL-1:0] p0_cmd, p1_cmd;
  logic      busy_start, busy_end;

  int        tr_sel   [5] = '{0, 4, 11, 12, 3};
  logic      tr_noise [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [N-1:0] tr_vec [5] = '{8'h00, 8'h01, 8'h80, 8'h00, 8'h00};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_inputs(input logic done);
    for (int i = 0; i < N; i++) begin
      b0.dtw_score[i*SW +: SW] = sc[i];
      b1.dtw_score[i*SW +: SW] = sc[i];
    end
    b0.noise_score = nz;
    b1.noise_score = nz;
    b0.dtw_done    = {N{done}};
    b1.dtw_done    = {N{done}};
    b0.noise_done  = done;
    b1.noise_done  = done;
  endtask

  task automatic set_te(input logic te, input logic [SL-1:0] sel);
    b0.training_enable = te;
    b1.training_enable = te;
    b0.training_select = sel;
    b1.training_select = sel;
  endtask

  task automatic run_scan();
    apply_inputs(1'b1);
    p0_cnt = 0; p0_cyc = 0; p1_cnt = 0; stray = 0;
    p0_cmd = '0; p1_cmd = '0; busy_start = 1'b0; busy_end = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1)  busy_start = b0.busy;
      if (k == 14) busy_end   = b0.busy;
      if (b0.command_valid) begin p0_cnt++; p0_cyc = k; p0_cmd = b0.command; end
      else if (b0.command != '0) stray++;
      if (b1.command_valid) begin p1_cnt++; p1_cmd = b1.command; end
      else if (b1.command != '0) stray++;
    end
    apply_inputs(1'b0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    set_te(1'b0, '0);
    for (int i = 0; i < N; i++) sc[i] = '0;
    nz = '0;
    apply_inputs(1'b0);
    reset = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (b0.command !== 4'd0 || b0.command_valid !== 1'b0 || b0.busy !== 1'b0) begin
      errors++; $display("FAIL reset_cmd: command=%0d valid=%b busy=%b, required 0 0 0", b0.command, b0.command_valid, b0.busy);
    end
    checks++;
    if (b0.train !== 8'h00 || b0.noise_train !== 1'b0) begin
      errors++; $display("FAIL reset_train: train=%h noise_train=%b, required 00 0", b0.train, b0.noise_train);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    sc = '{900, 500, 700, 800, 600, 950, 990, 999};
    nz = 1000;
    run_scan();
    checks++;
    if (p0_cnt !== 1) begin errors++; $display("FAIL basic_pulses: got %0d, required 1", p0_cnt); end
    checks++;
    if (p0_cyc !== 10) begin errors++; $display("FAIL basic_latency: pulse at step %0d, required 10", p0_cyc); end
    checks++;
    if (p0_cmd !== 4'd5) begin errors++; $display("FAIL basic_cmd: got %0d, required 5", p0_cmd); end
    checks++;
    if (p1_cmd !== 4'd5) begin errors++; $display("FAIL basic_cmd_margin: got %0d, required 5", p1_cmd); end
    checks++;
    if (busy_start !== 1'b1 || busy_end !== 1'b0) begin
      errors++; $display("FAIL basic_busy: start=%b end=%b, required 1 0", busy_start, busy_end);
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL basic_stray_cmd: got %0d, required 0", stray); end
  endtask

  task automatic test_no_match();
    for (int i = 0; i < N; i++) sc[i] = 1200 + i;
    nz = 1000;
    run_scan();
    checks++;
    if (p0_cnt !== 1 || p0_cmd !== 4'd0) begin
      errors++; $display("FAIL no_match: pulses=%0d cmd=%0d, required 1 0", p0_cnt, p0_cmd);
    end
  endtask

  task automatic test_tie();
    sc = '{900, 900, 300, 900, 900, 300, 900, 900};
    nz = 1000;
    run_scan();
    checks++;
    if (p0_cnt !== 1 || p0_cmd !== 4'd6) begin
      errors++; $display("FAIL tie_low_index: pulses=%0d cmd=%0d, required 1 6", p0_cnt, p0_cmd);
    end
  endtask

  task automatic test_margin();
    sc = '{980, 980, 980, 950, 980, 980, 980, 980};
    nz = 1000;
    run_scan();
    checks++;
    if (p0_cmd !== 4'd7) begin errors++; $display("FAIL margin0_accept: got %0d, required 7", p0_cmd); end
    checks++;
    if (p1_cnt !== 1 || p1_cmd !== 4'd0) begin
      errors++; $display("FAIL margin100_reject: pulses=%0d cmd=%0d, required 1 0", p1_cnt, p1_cmd);
    end
    sc[3] = 899;
    run_scan();
    checks++;
    if (p1_cnt !== 1 || p1_cmd !== 4'd7) begin
      errors++; $display("FAIL margin100_accept: pulses=%0d cmd=%0d, required 1 7", p1_cnt, p1_cmd);
    end
  endtask

  task automatic test_hold();
    int cnt;
    sc = '{900, 500, 700, 800, 600, 950, 990, 999};
    nz = 1000;
    cnt = 0;
    apply_inputs(1'b1);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (b0.command_valid) cnt++;
    end
    apply_inputs(1'b0);
    tick(); tick();
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL hold_single_pulse: got %0d, required 1", cnt); end
  endtask

  task automatic test_training();
    set_te(1'b1, '0);
    for (int i = 0; i < 5; i++) begin
      set_te(1'b1, SL'(tr_sel[i]));
      if (i > 0) begin
        checks++;
        if (b0.noise_train !== tr_noise[i-1] || b0.train !== tr_vec[i-1]) begin
          errors++; $display("FAIL train_lag_%0d: noise=%b train=%h, required %b %h", i, b0.noise_train, b0.train, tr_noise[i-1], tr_vec[i-1]);
        end
      end
      tick();
      checks++;
      if (b0.noise_train !== tr_noise[i] || b0.train !== tr_vec[i]) begin
        errors++; $display("FAIL train_sel_%0d: noise=%b train=%h, required %b %h", tr_sel[i], b0.noise_train, b0.train, tr_noise[i], tr_vec[i]);
      end
    end
    set_te(1'b0, 4'd4);
    tick();
    checks++;
    if (b0.noise_train !== 1'b0 || b0.train !== 8'h00) begin
      errors++; $display("FAIL train_disabled: noise=%b train=%h, required 0 00", b0.noise_train, b0.train);
    end
  endtask

  task automatic test_abort();
    int cnt;
    int bad;
    sc = '{900, 500, 700, 800, 600, 950, 990, 999};
    nz = 1000;
    cnt = 0;
    bad = 0;
    apply_inputs(1'b1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (b0.command_valid) cnt++;
      if (b0.command != '0) bad++;
      if (k == 3) set_te(1'b1, 4'd9);
    end
    checks++;
    if (cnt !== 0 || bad !== 0) begin
      errors++; $display("FAIL abort_no_cmd: pulses=%0d nonzero_cmd=%0d, required 0 0", cnt, bad);
    end
    checks++;
    if (b0.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", b0.busy); end
    set_te(1'b0, '0);
    apply_inputs(1'b0);
    tick(); tick();
  endtask

  task automatic test_reset_mid_scan();
    int cnt;
    logic busy_mid;
    sc = '{900, 500, 700, 800, 600, 950, 990, 999};
    nz = 1000;
    cnt = 0;
    apply_inputs(1'b1);
    for (int k = 1; k <= 4; k++) tick();
    busy_mid = b0.busy;
    reset = 1'b1;
    apply_inputs(1'b0);
    tick();
    checks++;
    if (busy_mid !== 1'b1 || b0.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_busy: before=%b after=%b, required 1 0", busy_mid, b0.busy);
    end
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (b0.command_valid) cnt++;
    end
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL reset_mid_no_pulse: got %0d, required 0", cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_match();
    test_tie();
    test_margin();
    test_hold();
    test_training();
    test_abort();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
